// File: rtl/data_mem_responder_if.sv
// Load/store bus between the load stations and the data memory responder.
// The requester drives the master side; the memory model is the slave.
interface data_mem_responder_if;
  logic        loadMem;
  logic [15:0] memAddr;
  logic        storeEn;
  logic [15:0] storeAddr;
  logic [15:0] storeData;
  logic        memReady;
  logic [15:0] memOut;
  logic        memBusy;

  modport master (
    output loadMem, memAddr,
    output storeEn, storeAddr, storeData,
    input  memReady, memOut, memBusy
  );

  modport slave (
    input  loadMem, memAddr,
    input  storeEn, storeAddr, storeData,
    output memReady, memOut, memBusy
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory model: one outstanding load with fixed latency,
// plus an independent single-cycle store port into the same word array.
module data_mem_responder #(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY must be 1..15");
  end
  if (ADDR_BITS < 1 || ADDR_BITS > 16) begin : g_bad_addr
    $error("data_mem_responder: ADDR_BITS must be 1..16");
  end

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT =
    4'(LATENCY >= 2 ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [15:0]          r_mem [DEPTH];
  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_req_addr;
  logic                 r_ready;
  logic                 r_busy;
  logic [15:0]          r_out;

  logic [ADDR_BITS-1:0] w_ld_idx;
  logic [ADDR_BITS-1:0] w_st_idx;

  assign w_ld_idx = bus.memAddr[ADDR_BITS-1:0];
  assign w_st_idx = bus.storeAddr[ADDR_BITS-1:0];

  // Upper address bits alias onto the array and are deliberately dropped.
  if (ADDR_BITS < 16) begin : g_alias
    logic w_unused_hi;
    assign w_unused_hi = ^{bus.memAddr[15:ADDR_BITS],
                           bus.storeAddr[15:ADDR_BITS]};
  end

  always_ff @(posedge clk) begin
    if (bus.storeEn) begin
      r_mem[w_st_idx] <= bus.storeData;
    end
  end

  // memOut samples the array with NBA, so a same-edge store is not seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_req_addr <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_out      <= '0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.loadMem) begin
            r_req_addr <= w_ld_idx;
            r_busy     <= 1'b1;
            if (LATENCY == 1) begin
              r_state <= RESP;
              r_ready <= 1'b1;
              r_out   <= r_mem[w_ld_idx];
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= RESP;
            r_ready <= 1'b1;
            r_out   <= r_mem[r_req_addr];
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memReady = r_ready;
  assign bus.memOut   = r_out;
  assign bus.memBusy  = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=3 instance for the
// main behaviour and a LATENCY=1 instance for the short-latency build.
module tb_data_mem_responder;

  logic clk;
  logic reset;

  data_mem_responder_if ia ();
  data_mem_responder_if ib ();

  data_mem_responder #(.ADDR_BITS(8), .LATENCY(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  data_mem_responder #(.ADDR_BITS(8), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] st_addr;
    logic [15:0] st_data;
    logic [15:0] ld_addr;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic store_a(input logic [15:0] a, input logic [15:0] d);
    ia.storeEn   = 1'b1;
    ia.storeAddr = a;
    ia.storeData = d;
    tick();
    ia.storeEn   = 1'b0;
  endtask

  task automatic store_b(input logic [15:0] a, input logic [15:0] d);
    ib.storeEn   = 1'b1;
    ib.storeAddr = a;
    ib.storeData = d;
    tick();
    ib.storeEn   = 1'b0;
  endtask

  // One load on the LATENCY=3 instance; samples cycles C0..C0+4.
  task automatic load_a(input logic [15:0] a,
                        input logic [15:0] exp,
                        input string name);
    logic [4:0]  rm;
    logic [4:0]  bm;
    logic [15:0] out_at;
    rm = '0;
    bm = '0;
    out_at = '0;
    ia.loadMem = 1'b1;
    ia.memAddr = a;
    for (int k = 0; k < 5; k++) begin
      rm[k] = ia.memReady;
      bm[k] = ia.memBusy;
      if (k == 3) out_at = ia.memOut;
      tick();
      if (k == 0) ia.loadMem = 1'b0;
    end
    check({name, ".ready"}, 32'(rm), 32'(5'b01000));
    check({name, ".busy"},  32'(bm), 32'(5'b01110));
    check({name, ".data"},  32'(out_at), 32'(exp));
    check({name, ".hold"},  32'(ia.memOut), 32'(exp));
  endtask

  initial begin
    logic [7:0]  rm8;
    logic [7:0]  bm8;
    logic [15:0] o3;
    logic [15:0] o7;
    logic        seen;
    logic [4:0]  rm5;
    logic [4:0]  bm5;
    logic [15:0] b1;
    logic [15:0] b3;

    vecs[0] = '{16'h0005, 16'hBEEF, 16'h0005, 16'hBEEF};
    vecs[1] = '{16'h0007, 16'h1234, 16'h0107, 16'h1234};
    vecs[2] = '{16'h00FF, 16'hA5A5, 16'hFFFF, 16'hA5A5};
    vecs[3] = '{16'h0100, 16'h0F0F, 16'h0000, 16'h0F0F};
    vecs[4] = '{16'h0010, 16'h5555, 16'h0010, 16'h5555};

    reset = 1'b1;
    ia.loadMem = 1'b0; ia.memAddr = '0;
    ia.storeEn = 1'b0; ia.storeAddr = '0; ia.storeData = '0;
    ib.loadMem = 1'b0; ib.memAddr = '0;
    ib.storeEn = 1'b0; ib.storeAddr = '0; ib.storeData = '0;

    #2;
    check("rst.ready", 32'(ia.memReady), 32'd0);
    check("rst.out",   32'(ia.memOut),   32'd0);
    check("rst.busy",  32'(ia.memBusy),  32'd0);
    check("rst1.out",  32'(ib.memOut),   32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Store then load in the next cycle, including aliased addresses.
    for (int i = 0; i < 5; i++) begin
      store_a(vecs[i].st_addr, vecs[i].st_data);
      load_a(vecs[i].ld_addr, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Store on the edge entering RESP must not reach memOut.
    store_a(16'h0009, 16'h0001);
    ia.loadMem = 1'b1;
    ia.memAddr = 16'h0009;
    tick();
    ia.loadMem = 1'b0;
    tick();
    ia.storeEn   = 1'b1;
    ia.storeAddr = 16'h0009;
    ia.storeData = 16'h0002;
    tick();
    ia.storeEn = 1'b0;
    check("rbw.ready", 32'(ia.memReady), 32'd1);
    check("rbw.data",  32'(ia.memOut),   32'h0001);
    tick();
    load_a(16'h0009, 16'h0002, "rbw.next");

    // loadMem held high: requests during WAIT/RESP are ignored.
    store_a(16'h0003, 16'h3333);
    store_a(16'h0004, 16'h4444);
    rm8 = '0;
    bm8 = '0;
    o3 = '0;
    o7 = '0;
    for (int k = 0; k < 8; k++) begin
      ia.loadMem = (k <= 6);
      ia.memAddr = (k == 0) ? 16'h0003 : 16'h0004;
      rm8[k] = ia.memReady;
      bm8[k] = ia.memBusy;
      if (k == 3) o3 = ia.memOut;
      if (k == 7) o7 = ia.memOut;
      tick();
    end
    ia.loadMem = 1'b0;
    check("hold.ready", 32'(rm8), 32'(8'b1000_1000));
    check("hold.busy",  32'(bm8), 32'(8'b1110_1110));
    check("hold.first", 32'(o3),  32'h3333);
    check("hold.second", 32'(o7), 32'h4444);
    tick();

    // Asynchronous reset while a load is pending.
    ia.loadMem = 1'b1;
    ia.memAddr = 16'h0005;
    tick();
    ia.loadMem = 1'b0;
    check("mid.busy_before", 32'(ia.memBusy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid.ready", 32'(ia.memReady), 32'd0);
    check("mid.busy",  32'(ia.memBusy),  32'd0);
    check("mid.out",   32'(ia.memOut),   32'd0);
    tick();
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | ia.memReady | ia.memBusy;
      tick();
    end
    check("mid.no_pulse", 32'(seen), 32'd0);
    load_a(16'h0005, 16'hBEEF, "mid.after");

    // LATENCY=1 build: accepted at C0 and C0+2.
    store_b(16'h0002, 16'h2222);
    store_b(16'h0003, 16'h3333);
    rm5 = '0;
    bm5 = '0;
    b1 = '0;
    b3 = '0;
    for (int k = 0; k < 5; k++) begin
      ib.loadMem = (k <= 2);
      ib.memAddr = (k == 0) ? 16'h0002 : 16'h0003;
      rm5[k] = ib.memReady;
      bm5[k] = ib.memBusy;
      if (k == 1) b1 = ib.memOut;
      if (k == 3) b3 = ib.memOut;
      tick();
    end
    ib.loadMem = 1'b0;
    check("lat1.ready", 32'(rm5), 32'(5'b01010));
    check("lat1.busy",  32'(bm5), 32'(5'b01010));
    check("lat1.first", 32'(b1),  32'h2222);
    check("lat1.second", 32'(b3), 32'h3333);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the load reservation-station fetch interface. It accepts one load request at a time on loadMem/memAddr, waits a fixed latency, then returns the word on memOut with a single-cycle memReady pulse. A separate one-cycle store port writes the same word array. The block sits between the load stations and the backing data store and models a multi-cycle data memory.

## Interface
- ADDR_BITS, 8: number of memAddr bits used to index the array; depth is 2^ADDR_BITS 16-bit words.
- LATENCY, 3: cycles from the request edge to the memReady cycle. Legal range is 1..15; values outside it are a synthesis error.
- clk input 1: the single clock; all state updates on the rising edge.
- reset input 1: asynchronous, active-high. Forces the controller to IDLE.
- loadMem input 1: load request. Sampled only in IDLE.
- memAddr input 16: load word address. Sampled with loadMem.
- storeEn input 1: write strobe, one word per asserted cycle.
- storeAddr input 16: store word address.
- storeData input 16: store data.
- memReady output 1: one-cycle pulse; memOut is valid in the same cycle.
- memOut output 16: returned load data. Holds its last value between responses.
- memBusy output 1: high in WAIT and RESP, i.e. while a request is outstanding.

## Operation
- Array: 2^ADDR_BITS × 16 bits, indexed by addr[ADDR_BITS-1:0]. Upper address bits are ignored, so addresses alias and wrap, e.g. 16'h0105 maps to index 5 when ADDR_BITS=8.
- Reset does not clear the contents. The bench initialises the array through the store port.
- State machine:
  - IDLE: loadMem=1 captures memAddr into reqAddr.
    - If LATENCY=1: go to RESP.
    - Otherwise: go to WAIT with cnt loaded to LATENCY-2.
  - WAIT: if cnt≠0, decrement cnt. If cnt=0, go to RESP. loadMem is ignored.
  - RESP: memReady=1, then go to IDLE unconditionally. loadMem is ignored.
- The memOut register loads array[reqAddr] on the edge that enters RESP.
  - The read is read-before-write: a store committed on that same edge is not visible in memOut.
  - A store to reqAddr on any earlier edge is visible.
- Store port:
  - storeEn=1 writes storeData to array[storeAddr] on the edge.
  - Independent of the controller state; accepted every cycle, including during WAIT and RESP.
- Only one request is outstanding at a time. A requester that keeps loadMem high through RESP gets a new request accepted in the IDLE cycle that follows, not in RESP.
- Reset mid-operation:
  - The pending request is dropped.
  - memReady=0 immediately, and no response pulse is ever produced for it.
  - The array is unchanged.

## Timing
- Reset values: memReady=0, memOut=16'h0000, memBusy=0, state IDLE, cnt=0, reqAddr=0.
- Request cycle C0 has loadMem=1 in IDLE. memReady is high in cycle C0+LATENCY only.
  - LATENCY=1: response in C0+1.
  - LATENCY=3: response in C0+3.
- memBusy is high in cycles C0+1 through C0+LATENCY inclusive.
- memReady is never high for two consecutive cycles.
- Minimum request spacing: next acceptance at C0+LATENCY+1, so throughput is one load per LATENCY+1 cycles.
- Store write latency is one edge. A load requested in the cycle after a store to the same address returns the new data.
- Outputs are registered (memReady, memOut, memBusy), with no combinational path from the inputs.

## Test plan
- Reset, then store 16'hBEEF to address 5, then loadMem with memAddr=5 at C0 (LATENCY=3) → memReady high only in C0+3, memOut=16'hBEEF, memBusy high C0+1..C0+3.
- Alias: ADDR_BITS=8, store 16'h1234 to address 16'h0007, then load address 16'h0107 → memOut=16'h1234.
- Read-before-write: load address 9 holding 16'h0001. Store 16'h0002 to address 9 in cycle C0+2, the edge entering RESP → memOut=16'h0001. A following load of address 9 returns 16'h0002.
- Ignored requests: hold loadMem=1 continuously with memAddr switching 3→4 in cycle C0+1 → exactly one response per LATENCY+1 cycles. The first response returns array[3].
- Reset asserted in cycle C0+1 of a pending load → memReady, memBusy and memOut go to 0 asynchronously, and no memReady pulse follows. A new load after reset release completes normally.
- LATENCY=1 build: request at C0 → memReady in C0+1. Back-to-back requests are accepted at C0 and C0+2.
